hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage RV32 core (F/D/E/M/W).
//  Adds to plain EX forwarding:
//   - load-use stall
//   - taken-branch/jump flush
//   - multi-cycle MDU stall sequencer
//   - saturating stall/flush performance counters
//  Sits beside the stage modules in the core top. Drives forward selects into
//  Execute, and stall/flush enables into the fetch/decode/execute/memory pipeline registers.
// PARAMETERS
//  REG_AW   5   register-index width (5 = 32 GPRs)
//  MDU_LAT  4   cycles a multi-cycle MDU op occupies E; legal 1..255; 1 = never stalls
//  CNT_W    16  width of each performance counter; legal 4..32
// PORTS
//  clk           in   1        rising-edge clock
//  reset         in   1        asynchronous, active-low reset
//  RS1D,RS2D     in   REG_AW   source regs of instr in D
//  RS1E,RS2E     in   REG_AW   source regs of instr in E
//  RDE,RDM,RDW   in   REG_AW   dest regs in E/M/W
//  RegWriteM     in   1        M instr writes RF
//  RegWriteW     in   1        W instr writes RF
//  MemReadE      in   1        E instr is a load (ResultSrcE==01)
//  PCSrcE        in   1        branch taken / jal / jalr resolved in E
//  MduStartE     in   1        E instr is an MDU op (held while op sits in E)
//  ForwardAE     out  2        00 RD1E, 01 ResultW, 10 ALUResultM
//  ForwardBE     out  2        same encoding for RD2E
//  StallF,StallD,StallE  out 1 hold PC / IF-ID / ID-EX regs
//  FlushD,FlushE,FlushM  out 1 bubble into IF-ID / ID-EX / EX-MEM
//  MduBusy       out  1        MDU stall active this cycle
//  StallCnt      out  CNT_W    cycles with StallF=1, saturating
//  FlushCnt      out  CNT_W    cycles with FlushD=1 or FlushE=1, saturating
// BEHAVIOUR
//  Reset (reset=0, async)
//   - mdu_cnt=0, StallCnt=0, FlushCnt=0.
//   - All comb outputs forced 0 while reset=0.
//  Forwarding (comb), shown for A; B identical with RS2E
//   - 10 if RegWriteM & RDM!=0 & RDM==RS1E.
//   - else 01 if RegWriteW & RDW!=0 & RDW==RS1E.
//   - else 00. M beats W; x0 never forwarded.
//  MDU sequencer: 8-bit mdu_cnt
//   - mdu_stall = (mdu_cnt==0) ? (MduStartE & MDU_LAT>1) : (mdu_cnt>1).
//   - mdu_cnt==0 & MduStartE & MDU_LAT>1: mdu_cnt<=MDU_LAT-1.
//   - mdu_cnt!=0: mdu_cnt<=mdu_cnt-1. MduStartE is ignored while mdu_cnt!=0.
//   - Op occupies E exactly MDU_LAT cycles. mdu_stall is high for the first
//     MDU_LAT-1 of them; in the last cycle the op advances.
//   - MduBusy = mdu_stall.
//  Load-use (comb)
//   - lw_stall = MemReadE & RDE!=0 & (RDE==RS1D | RDE==RS2D).
//  Priority, highest first
//   1. mdu_stall: StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0.
//      lw_stall and PCSrcE ignored; E holds the MDU op, never a branch.
//   2. PCSrcE: FlushD=FlushE=1, StallF=StallD=0. Squashes any lw_stall,
//      since the D instr is wrong-path.
//   3. lw_stall: StallF=StallD=1, FlushE=1.
//   4. else all stall/flush outputs 0.
//  Counters
//   - Each clk: StallCnt+=StallF, FlushCnt+=(FlushD|FlushE).
//   - Each saturates at 2^CNT_W-1 and never wraps.
//  Reset mid-MDU-op
//   - mdu_cnt clears immediately and stalls drop asynchronously.
//   - After release, MduStartE starts a fresh MDU_LAT sequence.
//  No combinational path from any output back to any input.
// TESTING
//  T1 RegWriteM=1,RDM=5; RegWriteW=1,RDW=5; RS1E=5 -> ForwardAE=10.
//     Then RDM=0, RDW=0 (x0 case) -> ForwardAE=00.
//  T2 MemReadE=1, RDE=7, RS2D=7 -> StallF=StallD=FlushE=1 for one cycle.
//     Same with RDE=0 -> no stall.
//  T3 lw_stall and PCSrcE both high -> FlushD=FlushE=1, StallF=0.
//     StallCnt unchanged; FlushCnt+1.
//  T4 MDU_LAT=4, MduStartE held 4 cycles -> StallF/D/E and FlushM =1,1,1,0.
//     MduBusy likewise; PCSrcE=1 in cycle 2 -> FlushD stays 0.
//  T5 MDU_LAT=4, reset=0 asserted in cycle 2 of an op -> all outputs 0 at once.
//     After release, MduStartE -> full 3-cycle stall again.
//  T6 CNT_W=4, hold lw_stall 20 cycles -> StallCnt climbs to 15 and stays there.
//     MDU_LAT=1 with MduStartE -> no stall ever.

Source files
------------

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-controller bundle: register indices and pipeline flags from the core in, forward selects,
// stall/flush enables and performance counters back out. Pure wiring, no latency, no backpressure.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] RS1D;
  logic [REG_AW-1:0] RS2D;
  logic [REG_AW-1:0] RS1E;
  logic [REG_AW-1:0] RS2E;
  logic [REG_AW-1:0] RDE;
  logic [REG_AW-1:0] RDM;
  logic [REG_AW-1:0] RDW;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              MemReadE;
  logic              PCSrcE;
  logic              MduStartE;

  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              MduBusy;
  logic [CNT_W-1:0]  StallCnt;
  logic [CNT_W-1:0]  FlushCnt;

  // Core side: drives the pipeline state, consumes the hazard controls.
  modport master (
    output RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW,
    output RegWriteM, RegWriteW, MemReadE, PCSrcE, MduStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, MduBusy, StallCnt, FlushCnt
  );

  modport slave (
    input  RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW,
    input  RegWriteM, RegWriteW, MemReadE, PCSrcE, MduStartE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, MduBusy, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// 5-stage RV32 hazard controller: forwarding, load-use stall, branch flush, MDU stall sequencer, counters.
// Controls are combinational from pipeline state (0 latency); counters update one cycle later; no backpressure.
module hazard_ctrl_unit #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  hazard_ctrl_unit_if.slave hz
);

  localparam bit               MDU_MULTI = (MDU_LAT > 1);
  localparam logic [7:0]       MDU_INIT  = 8'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [7:0]       mdu_cnt_q,   mdu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [1:0] fwd_a, fwd_b;
  logic       mdu_stall, lw_stall;
  logic       stall_f, stall_d, stall_e;
  logic       flush_d, flush_e, flush_m;

  // M result is younger than W, so it wins; x0 is hardwired and never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    if (hz.RegWriteM && (hz.RDM != '0) && (hz.RDM == hz.RS1E))
      fwd_a = 2'b10;
    else if (hz.RegWriteW && (hz.RDW != '0) && (hz.RDW == hz.RS1E))
      fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (hz.RegWriteM && (hz.RDM != '0) && (hz.RDM == hz.RS2E))
      fwd_b = 2'b10;
    else if (hz.RegWriteW && (hz.RDW != '0) && (hz.RDW == hz.RS2E))
      fwd_b = 2'b01;
  end

  always_comb begin
    mdu_stall = (mdu_cnt_q == 8'd0) ? (hz.MduStartE && MDU_MULTI) : (mdu_cnt_q > 8'd1);
    lw_stall  = hz.MemReadE && (hz.RDE != '0) &&
                ((hz.RDE == hz.RS1D) || (hz.RDE == hz.RS2D));
  end

  // A stalled MDU op owns E, so no branch can resolve there and the D instr just waits.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (mdu_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (mdu_cnt_q != 8'd0)
      mdu_cnt_d = mdu_cnt_q - 8'd1;
    else if (hz.MduStartE && MDU_MULTI)
      mdu_cnt_d = MDU_INIT;

    stall_cnt_d = stall_cnt_q;
    if (stall_f && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_ONE;

    flush_cnt_d = flush_cnt_q;
    if ((flush_d || flush_e) && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdu_cnt_q   <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset masks the combinational outputs so an in-flight stall drops immediately.
  always_comb begin
    hz.ForwardAE = reset ? fwd_a : 2'b00;
    hz.ForwardBE = reset ? fwd_b : 2'b00;
    hz.StallF    = reset & stall_f;
    hz.StallD    = reset & stall_d;
    hz.StallE    = reset & stall_e;
    hz.FlushD    = reset & flush_d;
    hz.FlushE    = reset & flush_e;
    hz.FlushM    = reset & flush_m;
    hz.MduBusy   = reset & mdu_stall;
    hz.StallCnt  = stall_cnt_q;
    hz.FlushCnt  = flush_cnt_q;
  end

endmodule
